// File: rtl/qcs_dyn_pre_gen_pkg.sv
// Shared types and constant tables for the dynamic HT preamble generator.
package qcs_dyn_pre_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_DIRECT = 1'b0,  // every stream uses sign +1
    MODE_HT     = 1'b1   // HT P-matrix signs applied per symbol
  } mode_e;

  // P-matrix as negate flags: bit n of row k set means P[k][n] = -1.
  // Rows: {+1,-1,+1,+1}, {+1,+1,-1,+1}, {+1,+1,+1,-1}, {-1,+1,+1,+1}.
  localparam logic [0:3][3:0] P_NEG = {4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // Cyclic shift (in samples) applied to each output channel.
  localparam logic [0:3][3:0] CSD = {4'd0, 4'd8, 4'd4, 4'd12};

  // Number of training symbols for a given streams-minus-one value.
  function automatic logic [2:0] sym_count(input logic [1:0] num_sts);
    case (num_sts)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/qcs_dyn_pre_gen_rom.sv
// LTF time-domain table, FFT_LEN entries of {I,Q}, one registered read port
// per channel. Table contents are a deterministic I ramp (entry 0 is the most
// negative code) and a permuted Q ramp; requires FFT_LEN <= 2**DW.
module qcs_dyn_pre_gen_rom #(
  parameter int DW      = 12,
  parameter int FFT_LEN = 64,
  parameter int NCH     = 4,
  localparam int AW     = $clog2(FFT_LEN)
) (
  input  logic                          clk,
  input  logic [NCH-1:0][AW-1:0]        addr,
  output logic [NCH-1:0][2*DW-1:0]      rd_data
);

  logic [2*DW-1:0] rom_mem [FFT_LEN];

  function automatic logic [2*DW-1:0] ltf_word(input int j);
    int step, half, iv, qv;
    step = (1 << DW) / FFT_LEN;
    half = 1 << (DW - 1);
    iv   = j * step - half;
    qv   = ((j * 23 + 7) % FFT_LEN) * step - half;
    return {DW'(iv), DW'(qv)};
  endfunction

  for (genvar j = 0; j < FFT_LEN; j++) begin : g_tab
    assign rom_mem[j] = ltf_word(j);
  end

  // Synchronous read, one port per channel.
  // NOTE: table and read registers carry no reset; a valid bit downstream qualifies the data.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) rd_data[k] <= rom_mem[addr[k]];
  end

endmodule

// File: rtl/qcs_dyn_pre_gen_mc.sv
// Multi-channel HT-LTF preamble generator: walks CP+body samples per symbol,
// applies per-channel cyclic shift and P-matrix sign, two-cycle latency.
module qcs_dyn_pre_gen_mc
  import qcs_dyn_pre_gen_pkg::*;
#(
  parameter int DW      = 12,
  parameter int NCH     = 4,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [1:0]        num_sts,
  input  logic              nhtp_re,
  output logic [NCH*DW-1:0] data_i,
  output logic [NCH*DW-1:0] data_q,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int AW      = $clog2(FFT_LEN);
  localparam int SYM_LEN = CP_LEN + FFT_LEN;
  localparam int SW      = $clog2(SYM_LEN);
  localparam logic [SW-1:0] S_LAST = SW'(SYM_LEN - 1);

  state_e                    state, state_nxt;
  logic [SW-1:0]             s;
  logic [2:0]                n;
  mode_e                     mode_r;
  logic [1:0]                nsts_r;
  logic                      start_ok, accept, last_issue, kill;
  logic                      v1;
  logic [1:0]                n1;
  logic [NCH-1:0][AW-1:0]    rom_addr;
  logic [NCH-1:0][2*DW-1:0]  rom_q;
  logic [NCH*DW-1:0]         i_nxt, q_nxt;

  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
    if (x == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    return -x;
  endfunction

  assign start_ok   = (state == ST_IDLE) && start && !abort;
  assign kill       = abort && (state != ST_IDLE);
  assign accept     = (state == ST_RUN) && nhtp_re && !abort;
  assign last_issue = accept && (s == S_LAST) && (n == sym_count(nsts_r) - 3'd1);

  // State register plus registered busy/done decoded from the next state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic; abort wins over every other transition.
  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (abort) state_nxt = ST_IDLE;
                else if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort) state_nxt = ST_IDLE;
                else if (!v1) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sample/symbol counters and per-preamble configuration latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s      <= '0;
      n      <= '0;
      mode_r <= MODE_DIRECT;
      nsts_r <= '0;
    end else if (start_ok) begin
      s      <= '0;
      n      <= '0;
      mode_r <= mode_e'(mode);
      nsts_r <= num_sts;
    end else if (accept) begin
      if (s == S_LAST) begin
        s <= '0;
        n <= n + 3'd1;
      end else begin
        s <= s + 1'b1;
      end
    end
  end

  // Table index per channel: (s - CP_LEN - CSD[k]) mod FFT_LEN via AW-bit wrap.
  always_comb begin
    rom_addr = '0;
    for (int k = 0; k < NCH; k++)
      rom_addr[k] = AW'(s) - AW'(CP_LEN) - AW'(CSD[k]);
  end

  qcs_dyn_pre_gen_rom #(
    .DW      (DW),
    .FFT_LEN (FFT_LEN),
    .NCH     (NCH)
  ) u_rom (
    .clk     (clk),
    .addr    (rom_addr),
    .rd_data (rom_q)
  );

  // Stage 1 tracks which issued sample (and its symbol) the ROM is returning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      n1 <= '0;
    end else begin
      v1 <= accept;
      n1 <= n[1:0];
    end
  end

  // Sign and stream masking applied to the ROM words.
  always_comb begin
    i_nxt = '0;
    q_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (2'(k) <= nsts_r) begin
        if ((mode_r == MODE_HT) && P_NEG[k][n1]) begin
          i_nxt[k*DW +: DW] = sat_neg(rom_q[k][DW +: DW]);
          q_nxt[k*DW +: DW] = sat_neg(rom_q[k][0 +: DW]);
        end else begin
          i_nxt[k*DW +: DW] = rom_q[k][DW +: DW];
          q_nxt[k*DW +: DW] = rom_q[k][0 +: DW];
        end
      end
    end
  end

  // Output register; data holds its last value when no sample is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_i    <= '0;
      data_q    <= '0;
    end else begin
      out_valid <= v1 && !kill;
      if (v1 && !kill) begin
        data_i <= i_nxt;
        data_q <= q_nxt;
      end
    end
  end

endmodule

// File: doc/qcs_dyn_pre_gen_mc.md
QCS_DYN_PRE_GEN_MC -- requirements
Module: qcs_dyn_pre_gen_mc

Interface
REQ-001 SHALL have parameter DW, default 12, I/Q sample width (signed, two's complement).
REQ-002 SHALL have parameter NCH, default 4, output channel count; legal range 1..4.
REQ-003 SHALL have parameter FFT_LEN, default 64, samples per symbol body (power of 2).
REQ-004 SHALL have parameter CP_LEN, default 16, cyclic-prefix samples per symbol (< FFT_LEN).
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse, begins a preamble when IDLE.
REQ-008 SHALL have port abort  in  1  terminates a preamble in progress.
REQ-009 SHALL have port mode  in  1  0 = no P-matrix (all signs +1), 1 = HT P-matrix applied.
REQ-010 SHALL have port num_sts  in  2  streams minus one (0..3), sampled on accepted start.
REQ-011 SHALL have port nhtp_re  in  1  read enable; sample index advances only when high.
REQ-012 SHALL have port data_i  out  NCH*DW  per-channel I samples, channel k at [k*DW +: DW].
REQ-013 SHALL have port data_q  out  NCH*DW  per-channel Q samples, same packing.
REQ-014 SHALL have port out_valid  out  1  data_i/data_q hold a valid sample.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse after last sample of a non-aborted preamble.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN when last sample index is issued, DRAIN->DONE when pipeline empties, DONE->IDLE after one cycle.
REQ-018 Symbol count SHALL be 1, 2, 4, 4 for num_sts 0, 1, 2, 3; each symbol is CP_LEN+FFT_LEN samples.
REQ-019 start SHALL be ignored outside IDLE; num_sts and mode SHALL be latched on accepted start and held for the preamble.
REQ-020 In RUN, sample counter s (0..CP_LEN+FFT_LEN-1) and symbol counter n SHALL advance only on cycles with nhtp_re high; s wraps to 0 and n increments at s = CP_LEN+FFT_LEN-1.
REQ-021 Channel k table index SHALL be (s - CP_LEN - CSD[k]) mod FFT_LEN, CSD = {0, 8, 4, 12} samples for k = 0..3.
REQ-022 Channel k output SHALL be table sample times P[k][n] when mode=1, times +1 when mode=0; P rows: {+1,-1,+1,+1}, {+1,+1,-1,+1}, {+1,+1,+1,-1}, {-1,+1,+1,+1}.
REQ-023 Negation SHALL saturate: -(-2^(DW-1)) yields 2^(DW-1)-1; no other arithmetic widening.
REQ-024 Channels k > num_sts SHALL output zero I and Q while out_valid is high.
REQ-025 Latency SHALL be exactly 2 cycles from a RUN cycle with nhtp_re high to out_valid high with that sample; out_valid is low otherwise.
REQ-026 Total out_valid cycles per non-aborted preamble SHALL equal symbols*(CP_LEN+FFT_LEN), independent of nhtp_re gaps.
REQ-027 abort in any non-IDLE state SHALL force IDLE next cycle, clear pipeline valid bits, suppress done; abort and start together in IDLE SHALL leave the block IDLE.
REQ-028 Outputs SHALL be registered; data_i/data_q SHALL hold last value when out_valid is low.

Reset
REQ-029 On reset: state IDLE, counters 0, out_valid 0, busy 0, done 0, data_i/data_q all zero.
REQ-030 Reset asserted mid-preamble SHALL abandon it with no done pulse; operation resumes only on a new start.

Structure
REQ-031 Package qcs_dyn_pre_gen_pkg SHALL hold the state enum, mode enum, P-matrix constant, CSD table and symbol-count function.
REQ-032 Sub-module qcs_dyn_pre_gen_rom SHALL hold the FFT_LEN x 2*DW LTF time-domain table with one-cycle synchronous read, one read port per channel.

Verification
REQ-033 num_sts=0, mode=0, nhtp_re constant high -> 80 out_valid cycles, channel 0 equals ROM[(s-16) mod 64], channels 1-3 zero, done 3 cycles after last accept.
REQ-034 num_sts=3, mode=1 -> 320 samples; symbol 1 channel 0 equals negated symbol 0 channel 0; channel 1 at s=16 equals ROM[56].
REQ-035 nhtp_re toggling 1/0 every cycle -> sample sequence identical to REQ-033, 160-cycle active span, still 80 valid samples.
REQ-036 ROM entry -2048 (DW=12) on a negated symbol -> output +2047.
REQ-037 abort at sample 40 of a 2-symbol preamble -> out_valid low within 1 cycle, busy low next cycle, no done; following start produces a full 160-sample preamble.
REQ-038 reset pulse mid-RUN, then start during DONE and RUN -> start ignored, all outputs zero after reset.
